// File: rtl/aes_sub_bytes_pipe.sv
// rtl/aes_sub_bytes_pipe.sv - multi-lane pipelined AES SubBytes engine (optional inverse map: SBOX_INV_EN)
module aes_sub_bytes_pipe #(
    parameter int NUM_BYTES   = 16,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   out_inv,
    output logic                   busy,
    output logic [CNT_W-1:0]       beat_cnt
);

    localparam int W = 8 * NUM_BYTES;

    // The S-box is computed algebraically (GF(2^8) inverse plus affine map)
    // rather than from a stored table, so both directions share gf_inv.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [W-1:0] sub_fwd(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < NUM_BYTES; i++) r[8*i +: 8] = sbox_fwd(x[8*i +: 8]);
        return r;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] y;
        y = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [W-1:0] sub_inv(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < NUM_BYTES; i++) r[8*i +: 8] = sbox_inv(x[8*i +: 8]);
        return r;
    endfunction
`endif

    // Mode entering the pipe; forced forward when the inverse lanes are not built
    logic in_mode;
`ifdef SBOX_INV_EN
    assign in_mode = in_inv;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign in_mode       = 1'b0;
`endif

    generate
        if (PIPE_STAGES == 1) begin : g_one
            logic         v0;
            logic [W-1:0] d0;
            logic         m0;
            logic         adv0;
            logic         load0;
            logic [W-1:0] lk;

`ifdef SBOX_INV_EN
            assign lk = in_mode ? sub_inv(in_data) : sub_fwd(in_data);
`else
            assign lk = sub_fwd(in_data);
`endif
            assign adv0  = v0 && out_ready;
            assign load0 = !v0 || adv0;

            // Single stage: substituted beat captured on accept, held under backpressure
            always_ff @(posedge clk) begin
                if (rst) begin
                    v0 <= 1'b0;
                    d0 <= '0;
                    m0 <= 1'b0;
                end else if (load0) begin
                    v0 <= in_valid;
                    if (in_valid) begin
                        d0 <= lk;
                        m0 <= in_mode;
                    end
                end
            end

            assign in_ready  = load0;
            assign out_valid = v0;
            assign out_data  = d0;
            assign out_inv   = m0;
            assign busy      = v0;
        end else if (PIPE_STAGES == 2) begin : g_two
            logic         v0, v1;
            logic [W-1:0] d0, d1;
            logic         m0, m1;
            logic         adv0, adv1;
            logic         load0, load1;
            logic [W-1:0] lk;

`ifdef SBOX_INV_EN
            assign lk = m0 ? sub_inv(d0) : sub_fwd(d0);
`else
            assign lk = sub_fwd(d0);
`endif
            assign adv1  = v1 && out_ready;
            assign load1 = !v1 || adv1;
            assign adv0  = v0 && load1;
            assign load0 = !v0 || adv0;

            // Stage 0: raw input beat, data only captured when a beat is accepted
            always_ff @(posedge clk) begin
                if (rst) begin
                    v0 <= 1'b0;
                    d0 <= '0;
                    m0 <= 1'b0;
                end else if (load0) begin
                    v0 <= in_valid;
                    if (in_valid) begin
                        d0 <= in_data;
                        m0 <= in_mode;
                    end
                end
            end

            // Stage 1: substituted beat presented downstream, held under backpressure
            always_ff @(posedge clk) begin
                if (rst) begin
                    v1 <= 1'b0;
                    d1 <= '0;
                    m1 <= 1'b0;
                end else if (load1) begin
                    v1 <= v0;
                    if (v0) begin
                        d1 <= lk;
                        m1 <= m0;
                    end
                end
            end

            assign in_ready  = load0;
            assign out_valid = v1;
            assign out_data  = d1;
            assign out_inv   = m1;
            assign busy      = v0 || v1;
        end else begin : g_bad
            $fatal(1, "aes_sub_bytes_pipe: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

    // Completed output handshakes, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
